// File: rtl/rate_sched_pkg.sv
// Shared types and terminal-count helper for the rate scheduler.
package rate_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SpeedEvery     = 2'b00,
    Speed1Hz       = 2'b01,
    SpeedHalfHz    = 2'b10,
    SpeedQuarterHz = 2'b11
  } speed_e;

  // Returns the divider terminal count; caller truncates to its counter width.
  function automatic logic [63:0] calc_tc(input logic [1:0] sel, input int unsigned clk_hz);
    logic [63:0] hz;
    hz      = 64'(clk_hz);
    calc_tc = 64'd0;
    case (sel)
      Speed1Hz:       calc_tc = hz - 64'd1;
      SpeedHalfHz:    calc_tc = (hz << 1) - 64'd1;
      SpeedQuarterHz: calc_tc = (hz << 2) - 64'd1;
      default:        calc_tc = 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/rate_sched_divider.sv
// Free-running divider counter: counts 0..tc while enabled, restart forces zero.
module rate_sched_divider #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] tc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_tc;

  assign at_tc = (cnt_q == tc);
  assign wrap  = en && !restart && at_tc;
  assign cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rate_sched_ctrl.sv
// Run/pause FSM, speed select and display count around the divider.
// Optional DONE state (stop at count 15) enabled by RATE_SCHED_DONE_EN.
module rate_sched_ctrl
  import rate_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 28
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [1:0]       speed_sel,
  output logic             tick,
  output logic [3:0]       count_out,
  output logic             running,
  output logic [CNT_W-1:0] cnt_out
);

  state_e           state_q, state_d;
  logic [1:0]       sel_q;
  logic             tick_q;
  logic [3:0]       count_q, count_d;
  logic             running_q;
  logic [CNT_W-1:0] tc;
  logic             sel_chg, active, en, restart, wrap;

  assign tc      = CNT_W'(calc_tc(sel_q, CLK_HZ));
  assign sel_chg = (speed_sel != sel_q);
  assign active  = (state_q == StRun) || (state_q == StPause);
  // A speed change restarts the period and suppresses any tick on that edge.
  assign en      = (state_q == StRun) && !clear && !stop && !sel_chg;
  assign restart = clear || (sel_chg && active) || (state_q == StIdle) || (state_q == StDone);

  rate_sched_divider #(
    .CNT_W (CNT_W)
  ) u_divider (
    .clk     (clk),
    .resetn  (resetn),
    .en      (en),
    .restart (restart),
    .tc      (tc),
    .cnt     (cnt_out),
    .wrap    (wrap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (wrap) begin
      count_d = count_q + 4'd1;
    end
    case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
`ifdef RATE_SCHED_DONE_EN
        end else if (wrap && (count_q == 4'd14)) begin
          state_d = StDone;
`endif
        end
      end
      StPause: begin
        if (start && !stop) state_d = StRun;
      end
`ifdef RATE_SCHED_DONE_EN
      StDone: begin
        state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      sel_q     <= SpeedEvery;
      tick_q    <= 1'b0;
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= speed_sel;
      tick_q    <= wrap;
      count_q   <= count_d;
      running_q <= (state_d == StRun);
    end
  end

  assign tick      = tick_q;
  assign count_out = count_q;
  assign running   = running_q;

endmodule

// File: tb/tb_rate_sched_ctrl.sv
// Self-checking bench for rate_sched_ctrl (CLK_HZ=4): table vectors, directed corners, random.
module tb_rate_sched_ctrl;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned CNT_W  = 5;
`ifdef RATE_SCHED_DONE_EN
  localparam bit DoneEn = 1'b1;
`else
  localparam bit DoneEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             start, stop, clear;
  logic [1:0]       speed_sel;
  logic             tick;
  logic [3:0]       count_out;
  logic             running;
  logic [CNT_W-1:0] cnt_out;

  always #5 clk = ~clk;

  rate_sched_ctrl #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .speed_sel (speed_sel),
    .tick      (tick),
    .count_out (count_out),
    .running   (running),
    .cnt_out   (cnt_out)
  );

  int nvec  = 0;
  int nfail = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done.
  int m_mode, m_cnt, m_count, m_sel;
  bit m_tick;

  function automatic int tc_of(input int sel);
    if (sel == 0) return 0;
    return (CLK_HZ << (sel - 1)) - 1;
  endfunction

  function automatic int pack(input int t, input int cnto, input int r, input int c);
    return (t << 16) | (cnto << 12) | (r << 8) | c;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_count = 0; m_sel = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input int sel);
    bit chg;
    chg    = (sel != m_sel);
    m_tick = 0;
    if (c) begin
      m_mode = 0; m_cnt = 0; m_count = 0;
    end else begin
      case (m_mode)
        0: begin
          m_cnt = 0;
          if (s && !p) m_mode = 1;
        end
        1: begin
          if (chg) m_cnt = 0;
          else if (!p) begin
            if (m_cnt == tc_of(m_sel)) begin
              m_cnt   = 0;
              m_tick  = 1;
              m_count = (m_count + 1) % 16;
              if (DoneEn && m_count == 15) m_mode = 3;
            end else begin
              m_cnt = m_cnt + 1;
            end
          end
          if (p) m_mode = 2;
        end
        2: begin
          if (chg) m_cnt = 0;
          if (s && !p) m_mode = 1;
        end
        default: ;
      endcase
    end
    m_sel = sel;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int dut_pack();
    return pack(int'(tick), int'(count_out), int'(running), int'(cnt_out));
  endfunction

  task automatic step(input bit s, input bit p, input bit c, input logic [1:0] sel,
                      input string tag);
    start = s; stop = p; clear = c; speed_sel = sel;
    @(posedge clk);
    model_step(s, p, c, int'(sel));
    #1;
    chk(tag, dut_pack(), pack(int'(m_tick), m_count, int'(m_mode == 1), m_cnt));
  endtask

  typedef struct {
    bit         st;
    bit         sp;
    bit         clr;
    logic [1:0] sel;
    int         e_tick;
    int         e_count;
    int         e_run;
    int         e_cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    bit s, p, c;
    logic [1:0] rsel;

    tbl[0]  = '{0, 0, 0, 2'b01, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 2'b01, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 2'b01, 0, 0, 1, 1};
    tbl[3]  = '{0, 0, 0, 2'b01, 0, 0, 1, 2};
    tbl[4]  = '{0, 0, 0, 2'b01, 0, 0, 1, 3};
    tbl[5]  = '{0, 0, 0, 2'b01, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 2'b01, 0, 1, 1, 1};
    tbl[7]  = '{0, 1, 0, 2'b01, 0, 1, 0, 1};
    tbl[8]  = '{1, 1, 0, 2'b01, 0, 1, 0, 1};
    tbl[9]  = '{1, 0, 0, 2'b01, 0, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 2'b01, 0, 1, 1, 2};
    tbl[11] = '{0, 0, 1, 2'b01, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 2'b00, 0, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 2'b00, 1, 1, 1, 0};
    tbl[14] = '{0, 0, 0, 2'b00, 1, 2, 1, 0};
    tbl[15] = '{0, 0, 0, 2'b01, 0, 2, 1, 0};
    tbl[16] = '{0, 0, 0, 2'b01, 0, 2, 1, 1};

    resetn = 1'b0; start = 0; stop = 0; clear = 0; speed_sel = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_pack(), 0);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].clr; speed_sel = tbl[i].sel;
      @(posedge clk);
      model_step(tbl[i].st, tbl[i].sp, tbl[i].clr, int'(tbl[i].sel));
      #1;
      chk($sformatf("tbl[%0d]", i), dut_pack(),
          pack(tbl[i].e_tick, tbl[i].e_count, tbl[i].e_run, tbl[i].e_cnt));
    end

    // Pause/resume at sel=10 (TC=7)
    step(0, 0, 1, 2'b10, "pause_clear");
    step(1, 0, 0, 2'b10, "pause_start");
    n = 0;
    while (cnt_out != 5 && n < 40) begin
      step(0, 0, 0, 2'b10, "pause_run");
      n++;
    end
    chk("pause_reach_cnt5", int'(cnt_out), 5);
    step(0, 1, 0, 2'b10, "pause_stop");
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 2'b10, "pause_idle");
      chk("pause_hold", int'(tick) * 100 + int'(cnt_out), 5);
    end
    step(1, 0, 0, 2'b10, "resume");
    chk("resume_no_tick", int'(tick), 0);
    n = 0;
    do begin
      step(0, 0, 0, 2'b10, "resume_run");
      n++;
    end while (!tick && n < 20);
    chk("resume_latency", n, 3);
    step(1, 1, 0, 2'b10, "start_stop");
    chk("start_stop_pauses", int'(running), 0);

    // Speed change 11 -> 01 at cnt=9
    step(0, 0, 1, 2'b11, "sel_clear");
    step(1, 0, 0, 2'b11, "sel_start");
    n = 0;
    while (cnt_out != 9 && n < 40) begin
      step(0, 0, 0, 2'b11, "sel_run");
      n++;
    end
    chk("sel_reach_cnt9", int'(cnt_out), 9);
    step(0, 0, 0, 2'b01, "sel_change");
    chk("sel_change_cnt_tick", int'(tick) * 100 + int'(cnt_out), 0);
    n = 0;
    do begin
      step(0, 0, 0, 2'b01, "sel_after");
      n++;
    end while (!tick && n < 20);
    chk("sel_change_latency", n, 4);

    // Wrap / done at sel=00
    step(0, 0, 1, 2'b00, "wrap_clear");
    step(1, 0, 0, 2'b00, "wrap_start");
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 2'b00, "wrap_run");
      ticks += int'(tick);
    end
`ifdef RATE_SCHED_DONE_EN
    chk("done_ticks", ticks, 15);
    chk("done_state", pack(int'(tick), int'(count_out), int'(running), 0), pack(0, 15, 0, 0));
    step(1, 0, 0, 2'b00, "done_start");
    chk("done_start_ignored", int'(running) * 100 + int'(count_out), 15);
    step(0, 0, 1, 2'b00, "done_clear");
    chk("done_clear", int'(running) * 100 + int'(count_out), 0);
    step(1, 0, 0, 2'b00, "done_restart");
    chk("done_restart_runs", int'(running), 1);
`else
    chk("wrap_ticks", ticks, 16);
    chk("wrap_state", int'(running) * 100 + int'(count_out), 100);
`endif

    // Asynchronous reset mid-run
    step(0, 0, 1, 2'b01, "rst_clear");
    step(1, 0, 0, 2'b01, "rst_start");
    step(0, 0, 0, 2'b01, "rst_run");
    step(0, 0, 0, 2'b01, "rst_run");
    step(0, 0, 0, 2'b01, "rst_run");
    step(0, 0, 0, 2'b01, "rst_run");
    start = 0;
    #2 resetn = 1'b0;
    #1;
    chk("async_reset", dut_pack(), 0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    step(0, 0, 0, 2'b01, "post_reset_idle");
    step(1, 0, 0, 2'b01, "post_reset_start");
    chk("post_reset_runs", int'(running), 1);

    // Random stimulus against the model
    rsel = 2'b01;
    for (int i = 0; i < 500; i++) begin
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) rsel = 2'($urandom_range(0, 3));
      step(s, p, c, rsel, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
